// File: rtl/sum_latch_pkg.sv
// Shared constants and width helpers for the sum latch bank.
package sum_latch_pkg;

  // Write mode selection on the shared mode input
  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Level that synchroniser and edge history flops take in reset ("pressed")
  localparam logic STROBE_RESET = 1'b0;

  // Width of the cross-channel sum: enough headroom that it can never overflow
  function automatic int unsigned sum_w(input int unsigned width,
                                        input int unsigned channels);
    return width + unsigned'($clog2(channels)) + 1;
  endfunction

endpackage

// File: rtl/sum_latch_bank_strobe_sync_edge.sv
// Synchroniser chain plus falling-edge detector for one active-low strobe.
module strobe_sync_edge
  import sum_latch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Shift the raw strobe through the chain; history keeps the last synced level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], strobe_n};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the pressed level so a strobe held low through reset never fires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{STROBE_RESET}};
      hist_q <= STROBE_RESET;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // One-cycle pulse on each synchronised high-to-low transition
  assign pulse = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sum_latch_bank.sv
// Bank of strobe-loaded data latches with load/accumulate and a registered total.
module sum_latch_bank
  import sum_latch_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CHANNELS    = 2,
  parameter bit          SATURATE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 mode,
  input  logic [CHANNELS-1:0]                  save_n,
  input  logic [WIDTH-1:0]                     data_in,
  output logic [CHANNELS*WIDTH-1:0]            q,
  output logic [CHANNELS-1:0]                  ovf,
  output logic [sum_w(WIDTH, CHANNELS)-1:0]    sum_out,
  output logic [CHANNELS-1:0]                  wr_ack
);

  localparam int unsigned    SUM_W    = sum_w(WIDTH, CHANNELS);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [CHANNELS-1:0] wr_pulse;
  logic [WIDTH-1:0]    chan_val [CHANNELS];
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    logic [WIDTH-1:0] chan_q;
    logic [WIDTH-1:0] chan_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ack_q;
    logic             ack_d;
    logic [WIDTH:0]   acc_sum;

    strobe_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .strobe_n (save_n[g]),
      .pulse    (wr_pulse[g])
    );

    // Next channel value: clear wins, then load or carry-aware accumulate
    always_comb begin
      acc_sum = (WIDTH+1)'(chan_q) + (WIDTH+1)'(data_in);
      chan_d  = chan_q;
      ovf_d   = ovf_q;
      ack_d   = 1'b0;
      if (clear) begin
        chan_d = '0;
        ovf_d  = 1'b0;
      end else if (wr_pulse[g]) begin
        ack_d = 1'b1;
        if (mode == MODE_LOAD) begin
          chan_d = data_in;
        end else if (acc_sum[WIDTH]) begin
          chan_d = SATURATE ? ALL_ONES : acc_sum[WIDTH-1:0];
          ovf_d  = 1'b1;
        end else begin
          chan_d = acc_sum[WIDTH-1:0];
        end
      end
    end

    // Channel contents, sticky overflow and write acknowledge
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chan_q <= '0;
        ovf_q  <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        chan_q <= chan_d;
        ovf_q  <= ovf_d;
        ack_q  <= ack_d;
      end
    end

    assign chan_val[g]              = chan_q;
    assign q[g*WIDTH +: WIDTH]      = chan_q;
    assign ovf[g]                   = ovf_q;
    assign wr_ack[g]                = ack_q;
  end

  // Zero-extended total of all channel registers
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum_d = sum_d + SUM_W'(chan_val[i]);
    end
  end

  // Registered total, one cycle behind the channel registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: tb/tb_sum_latch_bank.sv
// Scoreboard bench: one saturating and one wrapping bank driven by identical stimulus.
module tb_sum_latch_bank;

  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int SYNC = 2;
  localparam int SW   = W + $clog2(CH) + 1;
  localparam int MAXV = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              mode;
  logic [CH-1:0]     save_n;
  logic [W-1:0]      data_in;

  logic [CH*W-1:0]   q_s, q_w;
  logic [CH-1:0]     ovf_s, ovf_w, ack_s, ack_w;
  logic [SW-1:0]     sum_s, sum_w;

  sum_latch_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b1), .SYNC_STAGES(SYNC)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .save_n(save_n),
    .data_in(data_in), .q(q_s), .ovf(ovf_s), .sum_out(sum_s), .wr_ack(ack_s));

  sum_latch_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b0), .SYNC_STAGES(SYNC)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .save_n(save_n),
    .data_in(data_in), .q(q_w), .ovf(ovf_w), .sum_out(sum_w), .wr_ack(ack_w));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
    int            qs [CH];
    int            qw [CH];
    int            os [CH];
    int            ow [CH];
  } exp_t;

  exp_t exp_q[$];

  int mq_s [CH];
  int mq_w [CH];
  int mo_s [CH];
  int mo_w [CH];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pack_q(input int v [CH]);
    int r = 0;
    for (int i = 0; i < CH; i++) r = r | ((v[i] & MAXV) << (i * W));
    return r;
  endfunction

  function automatic int pack_f(input int v [CH]);
    int r = 0;
    for (int i = 0; i < CH; i++) r = r | ((v[i] & 1) << i);
    return r;
  endfunction

  function automatic int total(input int v [CH]);
    int r = 0;
    for (int i = 0; i < CH; i++) r += v[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      mq_s[i] = 0; mq_w[i] = 0; mo_s[i] = 0; mo_w[i] = 0;
    end
  endtask

  // Reference behaviour of one write on one channel, in plain integer arithmetic
  task automatic model_write(input int ch, input int d, input logic m);
    int s;
    if (m == 1'b0) begin
      mq_s[ch] = d;
      mq_w[ch] = d;
    end else begin
      s = mq_s[ch] + d;
      if (s > MAXV) begin mq_s[ch] = MAXV; mo_s[ch] = 1; end
      else mq_s[ch] = s;
      s = mq_w[ch] + d;
      if (s > MAXV) begin mq_w[ch] = s - (MAXV + 1); mo_w[ch] = 1; end
      else mq_w[ch] = s;
    end
  endtask

  // Press the selected strobes, hold them, release, then idle
  task automatic do_write(input logic [CH-1:0] mask, input int d, input logic m, input int hold);
    exp_t e;
    @(negedge clk);
    data_in = W'(d);
    mode    = m;
    save_n  = ~mask;
    for (int i = 0; i < CH; i++) if (mask[i]) model_write(i, d, m);
    e.cyc  = cyc + 1 + SYNC;
    e.mask = mask;
    e.qs = mq_s; e.qw = mq_w; e.os = mo_s; e.ow = mo_w;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    save_n = '1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q_sat"}, q_s, 0);
    check({tag, "_q_wrap"}, q_w, 0);
    check({tag, "_ovf_sat"}, ovf_s, 0);
    check({tag, "_ovf_wrap"}, ovf_w, 0);
  endtask

  // Monitor: every acknowledge must match the oldest expected write
  bit   sum_pending = 0;
  int   exp_sum_s, exp_sum_w;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sum_pending) begin
        check("sum_out_sat", sum_s, exp_sum_s);
        check("sum_out_wrap", sum_w, exp_sum_w);
        sum_pending = 0;
      end
      if (ack_s != '0 || ack_w != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {ack_w, ack_s}, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("ack_sat", ack_s, e.mask);
          check("ack_wrap", ack_w, e.mask);
          check("q_sat", q_s, pack_q(e.qs));
          check("q_wrap", q_w, pack_q(e.qw));
          check("ovf_sat", ovf_s, pack_f(e.os));
          check("ovf_wrap", ovf_w, pack_f(e.ow));
          exp_sum_s   = total(e.qs);
          exp_sum_w   = total(e.qw);
          sum_pending = 1;
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    mode    = 1'b0;
    save_n  = '1;
    data_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    check("por_sum", sum_s, 0);
    check("por_ack", {ack_w, ack_s}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Load with a long hold: exactly one write
    do_write(2'b01, 9, 1'b0, 10);
    // Load then accumulate with and without carry on channel 1
    do_write(2'b10, 5, 1'b0, 4);
    do_write(2'b10, 7, 1'b1, 4);
    do_write(2'b10, 6, 1'b1, 4);
    // Carry on channel 0, then a load leaves the overflow flag set
    do_write(2'b01, 12, 1'b0, 4);
    do_write(2'b01, 6, 1'b1, 5);
    do_write(2'b01, 3, 1'b0, 4);
    do_write(2'b11, 15, 1'b1, 6);

    // Clear coinciding with both write pulses
    @(negedge clk);
    data_in = W'(4'hA);
    mode    = 1'b0;
    save_n  = '0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check_all_zero("clr");
    @(negedge clk);
    check("clr_sum_sat", sum_s, 0);
    check("clr_sum_wrap", sum_w, 0);
    save_n = '1;
    repeat (3) @(negedge clk);
    do_write(2'b11, 4, 1'b0, 4);

    // Asynchronous reset mid-cycle, with channel 1 strobe going low alongside it
    @(posedge clk);
    #2;
    reset  = 1'b1;
    save_n = 2'b01;
    #1;
    model_clear();
    check_all_zero("arst");
    check("arst_sum", sum_s, 0);
    check("arst_ack", {ack_w, ack_s}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_all_zero("held_low");
    save_n = '1;
    repeat (3) @(negedge clk);
    do_write(2'b10, 11, 1'b0, 5);

    // Randomised traffic with occasional idle clears
    for (int n = 0; n < 50; n++) begin
      do_write(CH'($urandom_range(1, 3)), int'($urandom_range(0, MAXV)),
               ($urandom_range(0, 3) != 0), int'($urandom_range(4, 8)));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        check_all_zero("idle_clr");
      end
    end

    repeat (6) @(negedge clk);
    check("writes_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
